// File: rtl/hls_call_driver.sv
// Initiator for the ap_ctrl_hs handshake of one HLS kernel.
// Latches a job, pulses ap_start, captures ap_vld outputs, returns results.
module hls_call_driver #(
   parameter int DW      = 32,
   parameter int IN_W    = 640,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [IN_W-1:0]   req_data,
   output logic [IN_W-1:0]   call_args,
   output logic              call_start,
   input  logic              call_ready,
   input  logic              call_done,
   input  logic              call_idle,
   input  logic [DW-1:0]     res0,
   input  logic [DW-1:0]     res1,
   input  logic [DW-1:0]     res2,
   input  logic              res0_vld,
   input  logic              res1_vld,
   input  logic              res2_vld,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [3*DW-1:0]   rsp_data,
   output logic [1:0]        rsp_status,
   output logic              busy,
   output logic [CNT_W-1:0]  call_count
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_DONE,
      RESP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   timer_inc;
   logic [2:0]      got;
   logic [2:0]      vld;
   logic [3*DW-1:0] res_all;
   logic            in_call;
   logic            accept;
   logic            done_evt;
   logic            tmo_evt;
   logic            rsp_fire;

   assign vld       = {res2_vld, res1_vld, res0_vld};
   assign res_all   = {res2, res1, res0};
   assign in_call   = (state == START) || (state == WAIT_DONE);
   assign timer_inc = (timer == TW'(TIMEOUT)) ? timer : timer + TW'(1);
   assign req_ready = ap_rst_n && (state == IDLE) && call_idle;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // State register; reset drops call_start at once since it decodes state
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode, start pulse and one-cycle event strobes
   always_comb begin
      state_nxt  = state;
      call_start = 1'b0;
      accept     = 1'b0;
      done_evt   = 1'b0;
      tmo_evt    = 1'b0;
      rsp_fire   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept    = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            call_start = 1'b1;
            if (call_ready && call_done) begin
               done_evt = 1'b1;
            end else if (timer_inc == TW'(TIMEOUT)) begin
               tmo_evt = 1'b1;
            end else if (call_ready) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (call_done) begin
               done_evt = 1'b1;
            end else if (timer_inc == TW'(TIMEOUT)) begin
               tmo_evt = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (done_evt || tmo_evt) begin
         state_nxt = RESP;
      end
   end

   // Job latch, output capture, status, timer and completion counter
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         call_args  <= '0;
         rsp_data   <= '0;
         rsp_status <= '0;
         got        <= '0;
         timer      <= '0;
         call_count <= '0;
      end else begin
         if (accept) begin
            call_args  <= req_data;
            rsp_data   <= '0;
            rsp_status <= '0;
            got        <= '0;
            timer      <= '0;
         end else if (in_call) begin
            timer <= timer_inc;
            for (int k = 0; k < 3; k++) begin
               if (vld[k]) begin
                  rsp_data[k*DW +: DW] <= res_all[k*DW +: DW];
                  got[k]               <= 1'b1;
               end
            end
            if (done_evt) begin
               rsp_status <= {~&(got | vld), 1'b0};
            end else if (tmo_evt) begin
               rsp_status <= 2'b01;
            end
         end
         if (rsp_fire) begin
            call_count <= call_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hls_call_driver.sv
// Bench for hls_call_driver: behavioural ap_ctrl_hs kernel,
// directed jobs, scoreboard queue checked by a response monitor.
module tb_hls_call_driver;

   localparam int DW      = 32;
   localparam int IN_W    = 640;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 16;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [IN_W-1:0]   req_data = '0;
   logic [IN_W-1:0]   call_args;
   logic              call_start;
   logic              call_ready = 1'b0;
   logic              call_done = 1'b0;
   logic              call_idle = 1'b1;
   logic [DW-1:0]     res0 = '0;
   logic [DW-1:0]     res1 = '0;
   logic [DW-1:0]     res2 = '0;
   logic              res0_vld = 1'b0;
   logic              res1_vld = 1'b0;
   logic              res2_vld = 1'b0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [3*DW-1:0]   rsp_data;
   logic [1:0]        rsp_status;
   logic              busy;
   logic [CNT_W-1:0]  call_count;

   hls_call_driver #(
      .DW(DW), .IN_W(IN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .call_args(call_args),
      .call_start(call_start), .call_ready(call_ready),
      .call_done(call_done), .call_idle(call_idle),
      .res0(res0), .res1(res1), .res2(res2),
      .res0_vld(res0_vld), .res1_vld(res1_vld),
      .res2_vld(res2_vld),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_status(rsp_status),
      .busy(busy), .call_count(call_count)
   );

   always #5 ap_clk = ~ap_clk;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [3*DW-1:0] data;
      logic [1:0]      status;
   } exp_t;

   exp_t sb[$];

   int          k_lat   = 4;
   int          k_rdy   = 4;
   bit          k_hang  = 1'b0;
   bit          k_kill  = 1'b0;
   logic [2:0]  k_vmask = 3'b111;
   logic [DW-1:0] k_r0 = '0;
   logic [DW-1:0] k_r1 = '0;
   logic [DW-1:0] k_r2 = '0;
   bit          running = 1'b0;
   int          kc      = 0;

   int              start_cyc = 0;
   int              args_bad  = 0;
   logic [IN_W-1:0] cur_args  = '0;

   task automatic check(input string name,
                        input logic [IN_W-1:0] act,
                        input logic [IN_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Kernel model: reacts just after each rising edge
   always @(posedge ap_clk) begin
      #1;
      call_ready = 1'b0;
      call_done  = 1'b0;
      res0_vld   = 1'b0;
      res1_vld   = 1'b0;
      res2_vld   = 1'b0;
      res0       = 32'hBAD0_0000;
      res1       = 32'hBAD0_0001;
      res2       = 32'hBAD0_0002;
      if (k_kill) begin
         running = 1'b0;
      end else begin
         if (!running && call_start) begin
            running = 1'b1;
            kc      = 0;
         end
         if (running) begin
            kc++;
            if (kc == k_rdy) call_ready = 1'b1;
            if (!k_hang && kc == k_lat) begin
               call_done = 1'b1;
               res0_vld  = k_vmask[0];
               res1_vld  = k_vmask[1];
               res2_vld  = k_vmask[2];
               if (k_vmask[0]) res0 = k_r0;
               if (k_vmask[1]) res1 = k_r1;
               if (k_vmask[2]) res2 = k_r2;
               running   = 1'b0;
            end
         end
      end
      call_idle = !running;
   end

   bit prev_done = 1'b0;
   bit prev_rv   = 1'b0;
   int bc        = 0;

   // Response monitor: pops the scoreboard on each new response
   always @(negedge ap_clk) begin
      exp_t e;
      if (!ap_rst_n) begin
         prev_done = 1'b0;
         prev_rv   = 1'b0;
         bc        = 0;
      end else begin
         if (call_start) start_cyc++;
         if (busy && !rsp_valid && call_args !== cur_args) args_bad++;
         if (!busy) bc = 0;
         else if (!rsp_valid) bc++;
         if (rsp_valid && !prev_rv) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rsp_data", rsp_data, e.data);
               check("rsp_status", rsp_status, e.status);
               if (e.status[0]) check("timeout_cycles", bc, TIMEOUT);
               else check("rsp_latency", prev_done, 1);
            end
         end
         prev_rv   = rsp_valid;
         prev_done = call_done;
      end
   end

   task automatic issue(input logic [IN_W-1:0] d,
                        input logic [3*DW-1:0] ed,
                        input logic [1:0] es);
      bit   ok;
      exp_t e;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ap_clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("req_ready_wait", ok, 1);
      cur_args  = d;
      e.data    = ed;
      e.status  = es;
      sb.push_back(e);
      req_valid = 1'b1;
      req_data  = d;
      @(negedge ap_clk);
      req_valid = 1'b0;
      check("call_args_latch", call_args, d);
   endtask

   task automatic wait_idle(input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge ap_clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_wait", ok, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [IN_W-1:0] d;

      repeat (3) @(negedge ap_clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_call_start", call_start, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_count", call_count, 0);
      check("rst_status", rsp_status, 0);
      check("rst_data", rsp_data, 0);
      check("rst_args", call_args, 0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("idle_req_ready", req_ready, 1);

      k_lat = 4; k_rdy = 4; k_vmask = 3'b111;
      k_r0 = 32'd1; k_r1 = 32'd2; k_r2 = 32'd3;
      start_cyc = 0;
      d = {20{32'h1111_0001}};
      issue(d, {32'd3, 32'd2, 32'd1}, 2'b00);
      wait_idle(50);
      check("t1_count", call_count, 1);
      check("t1_start_cycles", start_cyc, 4);

      k_lat = 6; k_rdy = 1;
      k_r0 = 32'hA0; k_r1 = 32'hA1; k_r2 = 32'hA2;
      start_cyc = 0;
      d = {20{32'h2222_0002}};
      issue(d, {32'hA2, 32'hA1, 32'hA0}, 2'b00);
      wait_idle(50);
      check("t2_start_cycles", start_cyc, 1);
      check("t2_args_stable", args_bad, 0);

      k_hang = 1'b1; k_rdy = 0;
      d = {20{32'h3333_0003}};
      issue(d, '0, 2'b01);
      wait_idle(50);
      for (int i = 0; i < 4; i++) begin
         @(negedge ap_clk);
         check("t3_gated_ready", req_ready, 0);
      end
      k_kill = 1'b1;
      repeat (2) @(negedge ap_clk);
      check("t3_ready_after_idle", req_ready, 1);
      k_kill = 1'b0;
      k_hang = 1'b0;

      k_lat = 4; k_rdy = 4; k_vmask = 3'b101;
      k_r0 = 32'h10; k_r1 = 32'h20; k_r2 = 32'h30;
      d = {20{32'h4444_0004}};
      issue(d, {32'h30, 32'h0, 32'h10}, 2'b10);
      wait_idle(50);

      rsp_ready = 1'b0;
      k_lat = 3; k_rdy = 3; k_vmask = 3'b111;
      k_r0 = 32'h55; k_r1 = 32'h66; k_r2 = 32'h77;
      d = {20{32'h5555_0005}};
      issue(d, {32'h77, 32'h66, 32'h55}, 2'b00);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rsp_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge ap_clk);
      end
      check("t5_rsp_wait", ok, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge ap_clk);
         check("t5_data_hold", rsp_data, {32'h77, 32'h66, 32'h55});
         check("t5_req_ready", req_ready, 0);
      end
      check("t5_count_before", call_count, 4);
      rsp_ready = 1'b1;
      wait_idle(10);
      check("t5_count_after", call_count, 5);

      k_lat = 20; k_rdy = 1;
      d = {20{32'h6666_0006}};
      issue(d, '0, 2'b00);
      repeat (3) @(negedge ap_clk);
      check("t6_in_wait_busy", busy, 1);
      check("t6_in_wait_start", call_start, 0);
      ap_rst_n = 1'b0;
      #1;
      check("t6_rst_start", call_start, 0);
      check("t6_rst_rsp_valid", rsp_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_count", call_count, 0);
      void'(sb.pop_back());
      k_kill = 1'b1;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      k_kill = 1'b0;
      k_lat = 4; k_rdy = 4;
      k_r0 = 32'h9; k_r1 = 32'h8; k_r2 = 32'h7;
      d = {20{32'h7777_0007}};
      issue(d, {32'h7, 32'h8, 32'h9}, 2'b00);
      wait_idle(50);
      check("t6_count_after", call_count, 1);

      repeat (3) @(negedge ap_clk);
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
